// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared FSM state type, mode constants and pointer helper for the arbiter
//
// Purpose : Holds the state encoding used by priority_arbiter_rr and the
//           RR_MODE values understood by priority_arbiter_rr and prio_pick.
// Contents: arb_state_e (ARB_IDLE, ARB_GRANT)
//           ARB_FIXED / ARB_RR mode constants
//           arb_wrap_inc() modulo-N increment used for the round-robin pointer
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Increment with wrap at n; never yields a value >= n, so non-power-of-two
  // requester counts keep the pointer inside the valid range.
  function automatic int arb_wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational winner search, fixed-priority or round-robin
//
// Purpose : Finds the winning request line.
//           RR_MODE == ARB_FIXED : highest set index of req wins, ptr ignored.
//           RR_MODE == ARB_RR    : search order ptr, ptr+1, ..., N_REQ-1, 0, ...,
//                                  ptr-1; first set bit wins.
// Ports   : req   in  [N_REQ-1:0]  request lines
//           ptr   in  [IDX_W-1:0]  round-robin start position (< N_REQ)
//           idx   out [IDX_W-1:0]  winning index, 0 when nothing is requested
//           found out              at least one request line is set
module prio_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int RR_MODE = ARB_RR,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    if (RR_MODE == ARB_RR) begin
      // Walk N_REQ positions starting at ptr; the first hit is latched by
      // 'found' so later positions cannot override it.
      for (int k = 0; k < N_REQ; k++) begin
        pos = int'(ptr) + k;
        if (pos >= N_REQ) begin
          pos = pos - N_REQ;
        end
        pos_idx = IDX_W'(pos);
        if (!found && req[pos_idx]) begin
          found = 1'b1;
          idx   = pos_idx;
        end
      end
    end else begin
      // Ascending scan: the last (highest) set bit overwrites earlier ones.
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          found = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/priority_arbiter_rr.sv
// rtl/priority_arbiter_rr.sv - registered grant arbiter, fixed priority or round-robin
//
// Purpose : Offers one registered grant at a time to N_REQ requesters. A
//           grant is held stable until accepted (grant_valid && grant_ready);
//           on acceptance a new winner is loaded from the same cycle's req so
//           continuous ready gives one grant per cycle.
// Ports   : clock        in              rising-edge clock
//           reset        in              synchronous active-low reset
//           req          in  [N_REQ-1:0] request lines
//           grant_ready  in              consumer accepts the offered grant
//           grant_valid  out             registered grant offered
//           grant_idx    out [IDX_W-1:0] binary index of granted requester
//           grant_onehot out [N_REQ-1:0] one-hot of grant_idx, 0 when idle
//           req_any      out             combinational OR of req
module priority_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int RR_MODE = ARB_RR,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             req_any
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             accept;

  assign req_any = |req;

  // grant_valid is only high in ARB_GRANT, so ready is ignored while idle.
  assign accept = (state == ARB_GRANT) && grant_ready;

  // Fixed mode keeps the pointer parked at zero.
  assign ptr_next = (RR_MODE == ARB_RR) ? IDX_W'(arb_wrap_inc(int'(grant_idx), N_REQ))
                                        : '0;

  // The back-to-back winner must be searched from the post-acceptance pointer,
  // otherwise the requester just served could win again immediately.
  assign pick_ptr = accept ? ptr_next : ptr;

  prio_pick #(
    .N_REQ  (N_REQ),
    .RR_MODE(RR_MODE)
  ) u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      ptr          <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state        <= ARB_GRANT;
            grant_valid  <= 1'b1;
            grant_idx    <= pick_idx;
            grant_onehot <= N_REQ'(1) << pick_idx;
          end
        end
        ARB_GRANT: begin
          if (grant_ready) begin
            ptr <= ptr_next;
            if (pick_found) begin
              grant_idx    <= pick_idx;
              grant_onehot <= N_REQ'(1) << pick_idx;
            end else begin
              state        <= ARB_IDLE;
              grant_valid  <= 1'b0;
              grant_idx    <= '0;
              grant_onehot <= '0;
            end
          end
        end
        default: begin
          state        <= ARB_IDLE;
          grant_valid  <= 1'b0;
          grant_idx    <= '0;
          grant_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// tb/tb_priority_arbiter_rr.sv - self-checking bench for priority_arbiter_rr
module tb_priority_arbiter_rr;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 8-way round-robin instance
  logic       rst_a = 1'b0;
  logic [7:0] req_a = '0;
  logic       rdy_a = 1'b0;
  logic       val_a;
  logic [2:0] idx_a;
  logic [7:0] oh_a;
  logic       any_a;

  // 8-way fixed-priority instance
  logic       rst_f = 1'b0;
  logic [7:0] req_f = '0;
  logic       rdy_f = 1'b0;
  logic       val_f;
  logic [2:0] idx_f;
  logic [7:0] oh_f;
  logic       any_f;

  // 5-way round-robin instance
  logic       rst_5 = 1'b0;
  logic [4:0] req_5 = '0;
  logic       rdy_5 = 1'b0;
  logic       val_5;
  logic [2:0] idx_5;
  logic [4:0] oh_5;
  logic       any_5;

  priority_arbiter_rr #(.N_REQ(8), .RR_MODE(1)) u_rr8 (
    .clock(clock), .reset(rst_a), .req(req_a), .grant_ready(rdy_a),
    .grant_valid(val_a), .grant_idx(idx_a), .grant_onehot(oh_a), .req_any(any_a)
  );

  priority_arbiter_rr #(.N_REQ(8), .RR_MODE(0)) u_fx8 (
    .clock(clock), .reset(rst_f), .req(req_f), .grant_ready(rdy_f),
    .grant_valid(val_f), .grant_idx(idx_f), .grant_onehot(oh_f), .req_any(any_f)
  );

  priority_arbiter_rr #(.N_REQ(5), .RR_MODE(1)) u_rr5 (
    .clock(clock), .reset(rst_5), .req(req_5), .grant_ready(rdy_5),
    .grant_valid(val_5), .grant_idx(idx_5), .grant_onehot(oh_5), .req_any(any_5)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       exp_val;
    logic [2:0] exp_idx;
    logic [7:0] exp_oh;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Expected outputs are those visible after the edge that samples the inputs.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00});
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h01});
    for (int k = 1; k <= 9; k++) begin
      tbl.push_back('{1'b1, 8'hFF, 1'b1, 1'b1, 3'(k % 8), 8'(1 << (k % 8))});
    end
    // Hold idx 3 with ready low while req changes.
    tbl.push_back('{1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{1'b1, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{1'b1, 8'h10, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08});
    // Accept with no requests -> idle; ready ignored while idle.
    tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
    tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
    // Pointer sits at 4 after accepting 3.
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 3'd4, 8'h10});
    // Wrap from 7 to 0 and alternate.
    tbl.push_back('{1'b1, 8'h80, 1'b1, 1'b1, 3'd7, 8'h80});
    tbl.push_back('{1'b1, 8'h81, 1'b1, 1'b1, 3'd0, 8'h01});
    tbl.push_back('{1'b1, 8'h81, 1'b1, 1'b1, 3'd7, 8'h80});
    // Reset while idx 7 offered with ready high: no ptr update, restart at 0.
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00});
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h01});
    tbl.push_back('{1'b1, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h02});

    req_a = 8'hFF;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst;
      req_a = tbl[i].req;
      rdy_a = tbl[i].rdy;
      tick();
      chk($sformatf("rr8[%0d].valid", i), int'(val_a), int'(tbl[i].exp_val));
      chk($sformatf("rr8[%0d].idx", i), int'(idx_a), int'(tbl[i].exp_idx));
      chk($sformatf("rr8[%0d].onehot", i), int'(oh_a), int'(tbl[i].exp_oh));
      chk($sformatf("rr8[%0d].req_any", i), int'(any_a), int'(tbl[i].req != 8'h00));
    end
    rst_a = 1'b1;
    req_a = '0;
    rdy_a = 1'b0;

    // Fixed priority: 8'b0000_0101 always grants 2, never 0.
    rst_f = 1'b0;
    req_f = 8'h05;
    tick();
    chk("fx.reset_valid", int'(val_f), 0);
    chk("fx.reset_req_any", int'(any_f), 1);
    rst_f = 1'b1;
    rdy_f = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("fx[%0d].valid", i), int'(val_f), 1);
      chk($sformatf("fx[%0d].idx", i), int'(idx_f), 2);
      chk($sformatf("fx[%0d].onehot", i), int'(oh_f), 8'h04);
    end
    req_f = 8'h03;
    rdy_f = 1'b0;
    tick();
    chk("fx.hold_idx", int'(idx_f), 2);
    rdy_f = 1'b1;
    tick();
    chk("fx.next_idx", int'(idx_f), 1);
    chk("fx.next_onehot", int'(oh_f), 8'h02);
    req_f = 8'h00;
    tick();
    chk("fx.idle_valid", int'(val_f), 0);
    chk("fx.idle_onehot", int'(oh_f), 0);
    chk("fx.idle_req_any", int'(any_f), 0);
    rdy_f = 1'b0;

    // 5-way round-robin: 0..4 then 0, pointer never leaves range.
    rst_5 = 1'b0;
    req_5 = 5'h1F;
    tick();
    chk("rr5.reset_valid", int'(val_5), 0);
    rst_5 = 1'b1;
    rdy_5 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("rr5[%0d].valid", k), int'(val_5), 1);
      chk($sformatf("rr5[%0d].idx", k), int'(idx_5), k % 5);
      chk($sformatf("rr5[%0d].onehot", k), int'(oh_5), 1 << (k % 5));
    end
    req_5 = 5'h10;
    tick();
    chk("rr5.only4_idx", int'(idx_5), 4);
    req_5 = 5'h1F;
    tick();
    chk("rr5.wrap_after4", int'(idx_5), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
